// File: rtl/instruction_dispatcher_pkg.sv
// Shared opcode and FSM state encodings for the instruction dispatcher and its bench.
// The decode helper keeps the "does this opcode produce a payload" rule in one place.
package instruction_dispatcher_pkg;

  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_NOP     = 2'b00;
  localparam opcode_t OP_WRREG   = 2'b01;
  localparam opcode_t OP_WRMEM   = 2'b10;
  localparam opcode_t OP_ILLEGAL = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;

  function automatic logic is_dispatchable(input opcode_t op);
    return (op == OP_WRREG) || (op == OP_WRMEM);
  endfunction

endpackage

// File: rtl/instruction_dispatcher_sync_fifo.sv
// Synchronous FIFO with occupancy count; pushes when full and pops when empty are ignored.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/instruction_dispatcher.sv
// Pulls instruction words from a FIFO, decodes the opcode and presents register/memory
// writes to a demultiplexer with a valid/ack handshake; NOP and ILLEGAL words are dropped.
module instruction_dispatcher
  import instruction_dispatcher_pkg::*;
#(
  parameter int DATA_BITS  = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 selector,
  output logic [DATA_BITS-1:0] data,
  output logic                 out_valid,
  input  logic                 out_ack,
  output logic                 illegal,
  output logic [CW-1:0]        fifo_count,
  output logic [15:0]          dispatched
);

  logic [1:0]           state_r;
  logic [1:0]           state_nx_s;
  logic                 selector_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 out_valid_r;
  logic                 illegal_r;
  logic [15:0]          dispatched_r;

  logic [DATA_BITS-1:0] head_s;
  logic [CW-1:0]        count_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 push_s;
  logic                 pop_s;
  opcode_t              op_s;
  logic                 load_out_s;
  logic                 set_ill_s;
  logic                 ack_s;
  logic                 remain_s;
  logic                 nonempty_next_s;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_s),
    .push_data (in_data),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign in_ready   = !full_s;
  assign push_s     = in_valid && in_ready;
  assign pop_s      = (state_r == ST_LOAD) && !empty_s;
  assign op_s       = head_s[DATA_BITS-1 -: 2];
  // Occupancy after this edge: LOAD removes one word, a concurrent push adds one.
  assign remain_s        = (count_s > CW'(1)) || push_s;
  assign nonempty_next_s = !empty_s || push_s;

  assign selector   = selector_r;
  assign data       = data_r;
  assign out_valid  = out_valid_r;
  assign illegal    = illegal_r;
  assign fifo_count = count_s;
  assign dispatched = dispatched_r;

  // Next-state and action decode for IDLE/LOAD/HOLD.
  always_comb begin
    state_nx_s = state_r;
    load_out_s = 1'b0;
    set_ill_s  = 1'b0;
    ack_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (is_dispatchable(op_s)) begin
          load_out_s = 1'b1;
          state_nx_s = ST_HOLD;
        end else begin
          set_ill_s  = (op_s == OP_ILLEGAL);
          state_nx_s = remain_s ? ST_LOAD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (out_ack) begin
          ack_s      = 1'b1;
          state_nx_s = nonempty_next_s ? ST_LOAD : ST_IDLE;
        end else begin
          state_nx_s = ST_HOLD;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, held payload, sticky illegal flag and dispatch counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      selector_r   <= 1'b0;
      data_r       <= {DATA_BITS{1'b0}};
      out_valid_r  <= 1'b0;
      illegal_r    <= 1'b0;
      dispatched_r <= 16'h0000;
    end else begin
      state_r <= state_nx_s;
      if (load_out_s) begin
        selector_r  <= (op_s == OP_WRMEM);
        data_r      <= {2'b00, head_s[DATA_BITS-3:0]};
        out_valid_r <= 1'b1;
      end else if (ack_s) begin
        out_valid_r <= 1'b0;
      end
      if (set_ill_s) begin
        illegal_r <= 1'b1;
      end
      if (ack_s) begin
        dispatched_r <= dispatched_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Scoreboard bench: accepted words are decoded by a reference model into an expected
// payload queue; a monitor compares every presented payload and the status outputs.
module tb_instruction_dispatcher;
  import instruction_dispatcher_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        selector;
  logic [31:0] data;
  logic        out_valid;
  logic        out_ack = 1'b0;
  logic        illegal;
  logic [2:0]  fifo_count;
  logic [15:0] dispatched;

  instruction_dispatcher #(.DATA_BITS(32), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .selector   (selector),
    .data       (data),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .illegal    (illegal),
    .fifo_count (fifo_count),
    .dispatched (dispatched)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [31:0] data;
    bit          lat;
    int          pcyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [15:0] exp_disp = 16'h0;
  bit          exp_ill = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          front_seen = 1'b0;

  // Requests from the stimulus to the monitor, signalled by bumping a sequence number.
  int lat_seq = 0, full_seq = 0, force_seq = 0, idle_seq = 0;
  int lat_seen = 0, full_seen = 0, force_seen = 0, idle_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Monitor and reference model.
  always begin
    @(negedge clk or negedge reset_n);
    #1;
    if (!reset_n) begin
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_selector", {31'b0, selector}, 32'd0);
      chk("rst_data", data, 32'd0);
      chk("rst_illegal", {31'b0, illegal}, 32'd0);
      chk("rst_dispatched", {16'b0, dispatched}, 32'd0);
      chk("rst_fifo_count", {29'b0, fifo_count}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      exp_q.delete();
      exp_disp   = 16'h0;
      exp_ill    = 1'b0;
      front_seen = 1'b0;
    end else begin
      cyc++;
      if (force_seq != force_seen) begin
        force_seen = force_seq;
        exp_disp   = 16'hFFFF;
      end
      chk("in_ready", {31'b0, in_ready}, {31'b0, (fifo_count < 3'd4)});
      chk("dispatched", {16'b0, dispatched}, {16'b0, exp_disp});
      chk("illegal_not_early", {31'b0, illegal && !exp_ill}, 32'd0);
      if (full_seq != full_seen) begin
        full_seen = full_seq;
        chk("full_count", {29'b0, fifo_count}, 32'd4);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
      end
      if (idle_seq != idle_seen) begin
        idle_seen = idle_seq;
        chk("idle_pending", exp_q.size(), 32'd0);
        chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
        chk("idle_fifo_count", {29'b0, fifo_count}, 32'd0);
        chk("idle_illegal", {31'b0, illegal}, {31'b0, exp_ill});
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dispatch actual sel=%0d data=%h expected none", selector, data);
        end else begin
          e = exp_q[0];
          chk("selector", {31'b0, selector}, {31'b0, e.sel});
          chk("data", data, e.data);
          if (!front_seen && e.lat) begin
            chk("latency", cyc - e.pcyc, 32'd3);
          end
          front_seen = 1'b1;
          if (out_ack) begin
            void'(exp_q.pop_front());
            exp_disp   = exp_disp + 16'd1;
            front_seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        opcode_t op;
        exp_t    n;
        op     = in_data[31:30];
        n.sel  = (op == OP_WRMEM);
        n.data = in_data & 32'h3FFF_FFFF;
        n.pcyc = cyc;
        n.lat  = 1'b0;
        if (lat_seq != lat_seen) begin
          lat_seen = lat_seq;
          n.lat    = 1'b1;
        end
        if (op == OP_WRREG || op == OP_WRMEM) begin
          exp_q.push_back(n);
        end else if (op == OP_ILLEGAL) begin
          exp_ill = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ack  = 1'b1;
    repeat (30) tick();
    idle_seq++;
    tick();
  endtask

  logic [31:0] burst [5];

  initial begin
    burst[0] = 32'h4000_0011;
    burst[1] = 32'h8000_0022;
    burst[2] = 32'h4000_0033;
    burst[3] = 32'h8000_0044;
    burst[4] = 32'h4000_0055;

    #33 reset_n = 1'b1;
    repeat (2) tick();

    // Single register write with ack held high; latency from an idle block.
    out_ack = 1'b1;
    lat_seq++;
    push_word(32'h4000_00AA);
    drain();

    // Memory write held without ack, then a burst that fills the FIFO.
    out_ack = 1'b0;
    push_word(32'h8000_1234);
    repeat (6) tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = burst[i];
      if (i == 4) full_seq++;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    drain();

    // NOP and ILLEGAL are dropped; only the WRREG is dispatched.
    out_ack = 1'b1;
    push_word(32'h0000_0001);
    push_word(32'hC000_0000);
    push_word(32'h4000_0005);
    drain();

    // Counter wrap.
    force dut.dispatched_r = 16'hFFFF;
    force_seq++;
    tick();
    release dut.dispatched_r;
    push_word(32'h4000_0007);
    drain();

    // Randomized traffic and backpressure.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      r        = $urandom;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {2'($urandom_range(0, 3)), r[29:0]};
      out_ack  = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Asynchronous reset while holding a payload with words queued.
    out_ack = 1'b0;
    push_word(32'h4000_0100);
    repeat (4) tick();
    push_word(32'h8000_0200);
    push_word(32'h4000_0300);
    push_word(32'h8000_0400);
    #2 reset_n = 1'b0;
    #20 reset_n = 1'b1;
    tick();
    out_ack = 1'b1;
    repeat (15) tick();
    idle_seq++;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_dispatcher.md
INSTRUCTION_DISPATCHER -- requirements
Module: instruction_dispatcher

Interface
REQ-001 Parameter DATA_BITS, default 32, width of instruction words and output data.
REQ-002 Parameter FIFO_DEPTH, default 4, number of entries in the internal instruction FIFO; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  DATA_BITS  instruction word from the upstream source.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  FIFO can accept a word this cycle.
REQ-008 selector  output  1  demultiplexer select: 0 = register path, 1 = memory path.
REQ-009 data  output  DATA_BITS  payload to the demultiplexer data input.
REQ-010 out_valid  output  1  selector and data are valid and held.
REQ-011 out_ack  input  1  downstream has consumed the current payload.
REQ-012 illegal  output  1  sticky flag; an opcode-11 word was received.
REQ-013 fifo_count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 dispatched  output  16  count of completed dispatches.

Function
REQ-015 A push shall occur when in_valid and in_ready are both 1; in_ready shall equal (fifo_count < FIFO_DEPTH), using occupancy before any same-cycle pop; there shall be no full-bypass path.
REQ-016 The opcode shall be word[DATA_BITS-1:DATA_BITS-2]: 00 NOP, 01 WRREG, 10 WRMEM, 11 ILLEGAL.
REQ-017 The FSM shall have three states: IDLE, LOAD and HOLD.
REQ-018 IDLE: when fifo_count > 0, go to LOAD on the next edge; otherwise stay in IDLE.
REQ-019 LOAD: pop the FIFO head and decode it in one cycle.
REQ-020 LOAD, WRREG/WRMEM: register selector (0 or 1) and data = {2'b00, word[DATA_BITS-3:0]}, then go to HOLD.
REQ-021 LOAD, NOP: discard the word with no output change, then go to LOAD if more words remain, else IDLE.
REQ-022 LOAD, ILLEGAL: set illegal and discard the word, then go to LOAD if more words remain, else IDLE.
REQ-023 HOLD: out_valid shall be 1, and selector and data shall be stable while out_valid is 1.
REQ-024 HOLD with out_ack=1: drop out_valid, increment dispatched, then go to LOAD if the FIFO is non-empty at that edge, else IDLE.
REQ-025 out_ack shall be ignored in IDLE and LOAD.
REQ-026 Latency: a word pushed at edge N into an empty, idle block shall give out_valid=1 after edge N+2.
REQ-027 Throughput: one dispatch per two cycles when out_ack is held high.
REQ-028 A simultaneous push and pop shall leave fifo_count unchanged; pointers shall wrap modulo FIFO_DEPTH.
REQ-029 dispatched shall wrap from 0xFFFF to 0x0000.
REQ-030 illegal shall clear only on reset.

Reset
REQ-031 While reset_n=0, asynchronously: FSM=IDLE, FIFO pointers and count = 0, selector=0, data=0, out_valid=0, illegal=0, dispatched=0; in_ready=1 after reset.
REQ-032 A reset in any state, including HOLD, shall discard the held payload and all FIFO contents; operation resumes from IDLE on the first edge after reset_n rises.

Structure
REQ-033 Opcode constants (NOP, WRREG, WRMEM, ILLEGAL) and FSM state encodings shall live in a shared package/include file used by the decoder and the testbench.
REQ-034 The FIFO shall be a separate sub-module, sync_fifo, parameterized by width and depth, exposing push, pop, count, full and empty.
REQ-035 selector and data shall connect directly to the demultiplexer selector and data inputs with no intermediate logic.

Verification
REQ-036 Reset, then push 0x4000_00AA with out_ack=1 -> out_valid after edge 2; selector=0, data=0x0000_00AA; dispatched=1.
REQ-037 Push 0x8000_1234 and hold out_ack=0 for 5 cycles -> selector=1 and data=0x0000_1234 held stable for all 5 cycles; dispatched increments only on the ack.
REQ-038 Push 5 words back-to-back with out_ack=0 -> in_ready=0 after the 4th push; the 5th word is not accepted; fifo_count=4.
REQ-039 Push 0x0000_0001 (NOP), then 0xC000_0000 (ILLEGAL), then 0x4000_0005 -> only 0x0000_0005 is dispatched; illegal=1 and stays 1.
REQ-040 Assert reset_n=0 mid-HOLD with 3 words queued -> all outputs return to their reset values immediately; no dispatch occurs after release.
REQ-041 Force dispatched=0xFFFF, then complete one dispatch -> dispatched=0x0000.
